// File: rtl/clock_mode_pkg.sv
// Shared types and constants for the pushbutton-driven clock-mode controller.
package clock_mode_pkg;

    localparam int unsigned CNT_W = 25;

    localparam logic [1:0] MODE_FAST = 2'b00;
    localparam logic [1:0] MODE_SLOW = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } press_state_e;

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a stable-count debounce filter for one raw input.
module debounce_filter
    import clock_mode_pkg::*;
#(
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 25'd500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_deb
);

    localparam logic [CNT_W-1:0] DEB_LAST = DEBOUNCE_CYCLES - CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic [CNT_W-1:0] r_cnt;

    // The counter only runs while the synced level disagrees with the accepted one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt >= DEB_LAST) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Turns a debounced pushbutton and lock switch into the 2-bit mode code for the slow-clock divider.
module clock_mode_ctrl
    import clock_mode_pkg::*;
#(
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 25'd500000,
    parameter logic [CNT_W-1:0] LONG_CYCLES     = 25'd25000000,
    parameter logic [1:0]       DEFAULT_MODE    = 2'b00
) (
    input  logic       inclk,
    input  logic       reset_n,
    input  logic       mode_btn,
    input  logic       lock_sw,
    output logic [1:0] switch_clock,
    output logic       mode_changed
);

    localparam logic [CNT_W-1:0] LONG_LAST = LONG_CYCLES - CNT_W'(1);

    logic             w_btn_d;
    logic             w_lock_d;
    press_state_e     r_state;
    press_state_e     w_state_nxt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_nxt;
    logic [CNT_W-1:0] w_hold_inc;
    logic [1:0]       r_mode;
    logic [1:0]       w_mode_nxt;
    logic             r_changed;
    logic             w_changed_nxt;

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_filter (
        .i_clk   (inclk),
        .i_rst_n (reset_n),
        .i_raw   (mode_btn),
        .o_deb   (w_btn_d)
    );

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lock_filter (
        .i_clk   (inclk),
        .i_rst_n (reset_n),
        .i_raw   (lock_sw),
        .o_deb   (w_lock_d)
    );

    assign w_hold_inc = (r_hold_cnt == '1) ? r_hold_cnt : r_hold_cnt + CNT_W'(1);

    // Press classification; a lock suppresses the mode action but never the state move.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_mode_nxt  = r_mode;
        unique case (r_state)
            IDLE: begin
                if (w_btn_d) begin
                    w_state_nxt = HELD;
                    w_hold_nxt  = '0;
                end
            end
            HELD: begin
                if (!w_btn_d) begin
                    w_state_nxt = IDLE;
                    if (!w_lock_d) begin
                        w_mode_nxt = (r_mode == MODE_FAST) ? MODE_SLOW : MODE_FAST;
                    end
                end else begin
                    w_hold_nxt = w_hold_inc;
                    if (w_hold_inc >= LONG_LAST) begin
                        w_state_nxt = LONG;
                        if (!w_lock_d) begin
                            w_mode_nxt = MODE_FAST;
                        end
                    end
                end
            end
            LONG: begin
                if (!w_btn_d) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_changed_nxt = (w_mode_nxt != r_mode);
    end

    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_mode     <= DEFAULT_MODE;
            r_changed  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_mode     <= w_mode_nxt;
            r_changed  <= w_changed_nxt;
        end
    end

    always_ff @(posedge inclk) begin
        assert (DEFAULT_MODE == MODE_FAST || DEFAULT_MODE == MODE_SLOW)
            else $error("clock_mode_ctrl: DEFAULT_MODE must be 00 or 01");
    end

    assign switch_clock = r_mode;
    assign mode_changed = r_changed;

endmodule

// File: doc/clock_mode_ctrl.md
# clock_mode_ctrl

Generates the 2-bit clock-mode code that drives the `switch_clock` input of the slow-clock divider. It synchronises and debounces a raw pushbutton and a lock slide switch:
- A short press toggles between full-speed and divided operation.
- A long press forces full speed.
- The lock switch freezes the current mode.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 25'd500000: consecutive stable cycles needed to accept a new input level.
- `LONG_CYCLES`, default 25'd25000000: debounced hold length that counts as a long press.
- `DEFAULT_MODE`, default 2'b00: mode loaded at reset.

Ports:
- `inclk` in 1: the single clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `mode_btn` in 1: raw pushbutton, active-high, asynchronous to `inclk`.
- `lock_sw` in 1: raw slide switch, asynchronous; 1 = mode locked.
- `switch_clock` out 2: registered mode code to the divider (00 fast, 01 slow).
- `mode_changed` out 1: one-cycle pulse in the same cycle `switch_clock` takes a new value.

## Operation
- Each raw input goes through a 2-flop synchroniser and then a debounce filter.
- Debounce filter behaviour:
  - Counter increments while the synced value differs from the debounced value.
  - Counter clears whenever the two are equal.
  - When the counter reaches `DEBOUNCE_CYCLES`-1 and the values still differ, the debounced value flips on the next edge and the counter clears.
- Press FSM, running on the debounced button `btn_d`:
  - IDLE: on rising `btn_d` go to HELD and clear `hold_cnt`.
  - HELD: `hold_cnt` increments each cycle `btn_d`=1.
    - If `btn_d` falls first (short press), toggle the mode (00↔01) and go to IDLE.
    - If `hold_cnt` reaches `LONG_CYCLES`-1, force mode 00 and go to LONG.
  - LONG: wait for `btn_d`=0, then go to IDLE. Release does nothing else.
- Lock behaviour:
  - The debounced lock is sampled in the cycle the mode action would occur.
  - If locked, the action is suppressed, but the FSM still transitions.
- A mode action that leaves the code unchanged (long press while already 00) does not assert `mode_changed`.
- Only the codes 00 and 01 are ever driven. `DEFAULT_MODE` values other than 00/01 are illegal and are checked by a simulation assertion.
- Counter widths: 25 bits, saturating. `hold_cnt` does not wrap while in LONG.

## Timing
- Reset values:
  - `switch_clock`=`DEFAULT_MODE`, `mode_changed`=0.
  - Synchroniser flops, debounced values and counters = 0.
  - FSM = IDLE.
- Input latency:
  - A raw level that is stable from edge k appears at the synchroniser output at edge k+2.
  - The debounced value changes at edge k+2+`DEBOUNCE_CYCLES`.
- Short press: `switch_clock` and `mode_changed` update one edge after the debounced falling edge.
- Long press: `switch_clock` updates `LONG_CYCLES` edges after the debounced rising edge.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles, after synchronisation, are ignored entirely.
- Lock and press resolving in the same cycle: the lock's debounced value at that edge wins.
- Reset asserted mid-press: everything returns to reset values immediately. A button still held after reset release is treated as a fresh press once debounced.
- `mode_changed` is never high for two consecutive cycles.

## Structure
- Package `clock_mode_pkg` holds:
  - `MODE_FAST`=2'b00 and `MODE_SLOW`=2'b01.
  - The FSM state enum (IDLE, HELD, LONG).
  - Counter width `CNT_W`=25.
- One sub-module, `debounce_filter` (synchroniser + counter, parameter `DEBOUNCE_CYCLES`), instantiated twice: once for the button, once for the lock switch.
- The FSM and mode register live in the top module.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=10, `DEFAULT_MODE`=00.
- Reset, then idle for 20 cycles → `switch_clock`=00, `mode_changed` never 1.
- Button high for 8 cycles, then low → `switch_clock` 00→01 exactly 7 edges after the falling raw edge, with a single `mode_changed` pulse. Repeat → back to 00.
- 3-cycle button glitch, then 3 low cycles, then a 2-cycle glitch → no debounced change, `switch_clock` unchanged.
- From mode 01, hold the button 30 cycles → 00 at 2+4+10 edges after the raw rise. Release → no further change, one pulse total.
- `lock_sw`=1 (debounced), then a short press and a long press → `switch_clock` stays 01, no pulses. Unlock, then a short press → 00.
- Hold the button, assert `reset_n`=0 in HELD, keep the button high through reset release → outputs at reset values during reset. Debounced press is seen 6 edges after release. Releasing the button then toggles to 01.
